// File: rtl/led_matrix_scanner_pkg.sv
// Shared types and constants for the bicolour LED matrix scanner.
package led_matrix_pkg;

  localparam int unsigned MATRIX_DIM = 16;
  localparam int unsigned PWM_BITS   = 4;

  typedef logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] pixel_frame_t;
  typedef logic [MATRIX_DIM-1:0]                 line_t;
  typedef logic [$clog2(MATRIX_DIM)-1:0]         row_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BLANK,
    DRIVE
  } scan_state_t;

  // One-hot row select line for a given row index.
  function automatic line_t row_onehot(row_t r);
    line_t v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Pixel-frame inputs and LED pin outputs of the matrix scanner.
interface led_matrix_scanner_if;
  import led_matrix_pkg::*;

  logic                enable;
  logic [PWM_BITS-1:0] brightness;
  pixel_frame_t        RedPixels;
  pixel_frame_t        GrnPixels;
  line_t               RowSink;
  line_t               RedDriver;
  line_t               GrnDriver;
  row_t                row_idx;
  logic                frame_start;

  // Frame producer side (state logic / testbench).
  modport master (
    output enable, brightness, RedPixels, GrnPixels,
    input  RowSink, RedDriver, GrnDriver, row_idx, frame_start
  );

  // Scanner side.
  modport slave (
    input  enable, brightness, RedPixels, GrnPixels,
    output RowSink, RedDriver, GrnDriver, row_idx, frame_start
  );

endinterface

// File: rtl/led_matrix_scanner_scan_timer.sv
// Loadable down-counter with terminal count, plus an up-count view of the
// same interval used as the PWM phase.
module scan_timer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PHASE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [CNT_W-1:0]   load_val,
  output logic               tc,
  output logic [PHASE_W-1:0] phase_nxt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] up_q, up_d;

  // Next count: reload on request, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    up_d  = up_q;
    if (load) begin
      cnt_d = load_val;
      up_d  = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      up_d  = up_q + CNT_W'(1);
    end
  end

  assign tc        = (cnt_q == '0);
  assign phase_nxt = up_d[PHASE_W-1:0];

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      up_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      up_q  <= up_d;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Snapshots a 16x16 red/green frame at each frame start and scans it onto
// the LED matrix one row at a time, with blanking and PWM brightness.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROW_CYCLES   = 1024,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  led_matrix_scanner_if.slave  bus
);

  localparam int unsigned MAX_LEN    = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] ROW_LOAD   = CNT_W'(ROW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam row_t LAST_ROW = row_t'(MATRIX_DIM - 1);

  scan_state_t         state_q, state_d;
  row_t                row_q, row_d;
  pixel_frame_t        shadow_red_q, shadow_grn_q;
  logic                tmr_load, tmr_tc;
  logic [CNT_W-1:0]    tmr_load_val;
  logic [PWM_BITS-1:0] phase_nxt;
  line_t               sink_d, red_d, grn_d;
  line_t               sink_q, red_q, grn_q;
  logic                fs_d, fs_q;

  // Every state entry restarts the shared interval timer.
  assign tmr_load     = (state_d != state_q);
  assign tmr_load_val = (state_d == BLANK) ? BLANK_LOAD : ROW_LOAD;

  scan_timer #(
    .CNT_W   (CNT_W),
    .PHASE_W (PWM_BITS)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (tmr_load),
    .load_val  (tmr_load_val),
    .tc        (tmr_tc),
    .phase_nxt (phase_nxt)
  );

  // State and row-index registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Next-state and next-row logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE:  if (bus.enable) state_d = LOAD;
      LOAD:  state_d = BLANK;
      BLANK: if (tmr_tc) state_d = DRIVE;
      DRIVE: begin
        if (tmr_tc) begin
          if (row_q != LAST_ROW) begin
            state_d = BLANK;
            row_d   = row_q + row_t'(1);
          end else begin
            state_d = bus.enable ? LOAD : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == LOAD) row_d = '0;
  end

  // Frame snapshot taken during the LOAD cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_red_q <= '0;
      shadow_grn_q <= '0;
    end else if (state_q == LOAD) begin
      shadow_red_q <= bus.RedPixels;
      shadow_grn_q <= bus.GrnPixels;
    end
  end

  // Output decode. Built from the next state/row/phase so the registered
  // outputs line up with the state they belong to, not one cycle behind.
  always_comb begin
    sink_d = '0;
    red_d  = '0;
    grn_d  = '0;
    fs_d   = (state_d == LOAD);
    if (state_d == DRIVE) begin
      sink_d = row_onehot(row_d);
      if (phase_nxt < bus.brightness) begin
        red_d = shadow_red_q[row_d];
        grn_d = shadow_grn_q[row_d];
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sink_q <= '0;
      red_q  <= '0;
      grn_q  <= '0;
      fs_q   <= 1'b0;
    end else begin
      sink_q <= sink_d;
      red_q  <= red_d;
      grn_q  <= grn_d;
      fs_q   <= fs_d;
    end
  end

  assign bus.RowSink     = sink_q;
  assign bus.RedDriver   = red_q;
  assign bus.GrnDriver   = grn_q;
  assign bus.row_idx     = row_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner with short row/blank timing.
module tb_led_matrix_scanner;
  import led_matrix_pkg::*;

  localparam int ROWC   = 16;
  localparam int BLANKC = 2;
  localparam int SLOT   = ROWC + BLANKC;
  localparam int FRAME  = 1 + 16 * SLOT;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  led_matrix_scanner_if bus();

  led_matrix_scanner #(
    .ROW_CYCLES   (ROWC),
    .BLANK_CYCLES (BLANKC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sink;
    logic [15:0] red;
    logic [15:0] grn;
    logic [3:0]  row;
    logic        fs;
  } obs_t;

  typedef struct {
    logic [3:0]  bright;
    int          row;      // -1 means every row
    logic [15:0] red;
    logic [15:0] grn;
    int          exp_on;   // cycles with any column lit over one frame
  } vec_t;

  obs_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cnt_fs, cnt_sink, cnt_on, cnt_grn;
  logic [15:0] rows_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: position within a frame, advanced at each edge.
  int mpos = -1;
  int mrow = 0;
  pixel_frame_t mred = '0;
  pixel_frame_t mgrn = '0;

  always @(posedge clk) begin
    obs_t e;
    int j, r, o;
    if (!reset_n) begin
      mpos = -1; mrow = 0; mred = '0; mgrn = '0;
    end else if (mpos == -1) begin
      if (bus.enable) mpos = 0;
    end else if (mpos == 0) begin
      mred = bus.RedPixels;
      mgrn = bus.GrnPixels;
      mpos = 1;
    end else if (mpos == FRAME - 1) begin
      mpos = bus.enable ? 0 : -1;
    end else begin
      mpos++;
    end
    e = '0;
    if (reset_n && mpos >= 0) begin
      if (mpos == 0) begin
        mrow = 0;
        e.fs = 1'b1;
      end else begin
        j = mpos - 1;
        r = j / SLOT;
        o = j % SLOT;
        mrow = r;
        if (o >= BLANKC) begin
          e.sink = 16'(1) << r;
          if (((o - BLANKC) % 16) < int'(bus.brightness)) begin
            e.red = mred[r];
            e.grn = mgrn[r];
          end
        end
      end
    end
    e.row = 4'(mrow);
    exp_q.push_back(e);
  end

  // Scoreboard compare and activity counters.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.RowSink, bus.RedDriver, bus.GrnDriver, bus.row_idx, bus.frame_start};
      check("cycle", 64'(a), 64'(e));
    end
    if (bus.frame_start) cnt_fs++;
    if (bus.RowSink != '0) cnt_sink++;
    if ((bus.RedDriver | bus.GrnDriver) != '0) cnt_on++;
    if (bus.GrnDriver != '0) cnt_grn++;
    rows_seen |= bus.RowSink;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic zero_counts();
    cnt_fs = 0; cnt_sink = 0; cnt_on = 0; cnt_grn = 0; rows_seen = '0;
  endtask

  task automatic clear_pixels();
    bus.RedPixels = '0;
    bus.GrnPixels = '0;
  endtask

  task automatic wait_fs(input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (bus.frame_start) begin ok = 1; break; end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic wait_row(input logic [3:0] r, input bit need_drive, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < FRAME + 5; i++) begin
      tick(1);
      if (bus.row_idx == r && (!need_drive || bus.RowSink != '0)) begin ok = 1; break; end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'd15,  5, 16'h8001, 16'h0000,  15};
    vecs[1] = '{4'd4,  -1, 16'hFFFF, 16'hFFFF,  64};
    vecs[2] = '{4'd0,  -1, 16'hFFFF, 16'hFFFF,   0};
    vecs[3] = '{4'd8,  15, 16'h0000, 16'h1234,   8};
    vecs[4] = '{4'd1,   9, 16'hA5A5, 16'h5A5A,   1};
    vecs[5] = '{4'd15, -1, 16'h0F0F, 16'hF0F0, 240};

    bus.enable = 1'b0;
    bus.brightness = '0;
    clear_pixels();
    zero_counts();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;

    // Idle with enable low: nothing lights, no frame start.
    zero_counts();
    tick(50);
    check("idle_fs_count", 64'(cnt_fs), 64'd0);
    check("idle_sink_count", 64'(cnt_sink), 64'd0);

    // Table of single-frame scans.
    foreach (vecs[k]) begin
      clear_pixels();
      for (int r = 0; r < 16; r++) begin
        if (vecs[k].row < 0 || vecs[k].row == r) begin
          bus.RedPixels[r] = vecs[k].red;
          bus.GrnPixels[r] = vecs[k].grn;
        end
      end
      bus.brightness = vecs[k].bright;
      zero_counts();
      bus.enable = 1'b1;
      tick(1);
      bus.enable = 1'b0;
      tick(FRAME + 5);
      check("vec_on_cycles", 64'(cnt_on), 64'(vecs[k].exp_on));
      check("vec_fs_count", 64'(cnt_fs), 64'd1);
    end

    // Row 5 timing after frame start.
    clear_pixels();
    bus.RedPixels[5] = 16'h8001;
    bus.brightness = 4'd15;
    bus.enable = 1'b1;
    wait_fs(10, "row5_fs_seen");
    bus.enable = 1'b0;
    tick(5 * SLOT + BLANKC + 1);
    check("row5_sink", 64'(bus.RowSink), 64'h0020);
    check("row5_red", 64'(bus.RedDriver), 64'h8001);
    check("row5_grn", 64'(bus.GrnDriver), 64'h0000);
    tick(FRAME);

    // Mid-frame input change: only visible from the following frame.
    clear_pixels();
    bus.RedPixels[2] = 16'h00FF;
    bus.brightness = 4'd15;
    zero_counts();
    bus.enable = 1'b1;
    wait_fs(10, "tear_fs1_seen");
    tick(100);
    bus.GrnPixels[2] = 16'hF00F;
    bus.brightness = 4'd6;
    wait_fs(FRAME + 5, "tear_fs2_seen");
    check("tear_grn_frame1", 64'(cnt_grn), 64'd0);
    zero_counts();
    bus.enable = 1'b0;
    tick(FRAME + 5);
    check("tear_grn_frame2", 64'(cnt_grn), 64'd6);
    check("tear_fs_after", 64'(cnt_fs), 64'd0);

    // Enable dropped at row 7: frame completes, then idles.
    clear_pixels();
    bus.RedPixels[12] = 16'hFFFF;
    bus.brightness = 4'd15;
    bus.enable = 1'b1;
    wait_row(4'd7, 1'b0, "drop_row7_seen");
    bus.enable = 1'b0;
    zero_counts();
    tick(FRAME);
    check("drop_rows_seen", 64'(rows_seen), 64'hFF80);
    check("drop_row12_on", 64'(cnt_on), 64'd15);
    check("drop_no_fs", 64'(cnt_fs), 64'd0);
    zero_counts();
    tick(50);
    check("drop_idle_sink", 64'(cnt_sink), 64'd0);

    // Reset during DRIVE of row 3, then restart.
    clear_pixels();
    bus.RedPixels = '1;
    bus.brightness = 4'd15;
    bus.enable = 1'b1;
    wait_row(4'd3, 1'b1, "rst_row3_seen");
    reset_n = 1'b0;
    bus.enable = 1'b0;
    tick(1);
    check("rst_outputs", 64'({bus.RowSink, bus.RedDriver, bus.GrnDriver, bus.row_idx, bus.frame_start}), 64'd0);
    reset_n = 1'b1;
    tick(2);
    check("rst_idle_sink", 64'(bus.RowSink), 64'd0);
    bus.enable = 1'b1;
    tick(1);
    check("restart_fs", 64'(bus.frame_start), 64'd1);
    check("restart_row", 64'(bus.row_idx), 64'd0);
    bus.enable = 1'b0;
    tick(BLANKC + 1);
    check("restart_row0_sink", 64'(bus.RowSink), 64'h0001);
    tick(FRAME + 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
